led_frame_ctrl: RTL and testbench

Host-facing controller for the 4x8 LED matrix driver. It holds a double-buffered frame (back buffer written by the CPU bus, front buffer driving the matrix row inputs). It commits the back buffer to the front buffer only on a frame boundary, so the display never shows a half-written frame. It also sequences brightness through a frame-paced fade engine. The block sits between the SoC peripheral bus and `led_display`, and drives `leds1..leds4` and `leds_pwm`.

---
 rtl/led_ctrl_pkg.sv | 19 +
 rtl/led_fade.sv | 63 ++++++
 rtl/led_frame_ctrl.sv | 127 ++++++++++++
 tb/tb_led_frame_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/led_ctrl_pkg.sv
// Shared register map, STATUS layout and FSM state types for the LED frame controller.
package led_ctrl_pkg;

  localparam logic [2:0] ADDR_ROW0   = 3'd0;
  localparam logic [2:0] ADDR_ROW1   = 3'd1;
  localparam logic [2:0] ADDR_ROW2   = 3'd2;
  localparam logic [2:0] ADDR_ROW3   = 3'd3;
  localparam logic [2:0] ADDR_CTRL   = 3'd4;
  localparam logic [2:0] ADDR_BRIGHT = 3'd5;
  localparam logic [2:0] ADDR_STATUS = 3'd6;

  localparam int STAT_SWAP_BIT = 0;
  localparam int STAT_FADE_BIT = 1;
  localparam int STAT_PWM_LSB  = 2;

  typedef enum logic {SWAP_IDLE, SWAP_PENDING} swap_state_t;
  typedef enum logic {FADE_STEADY, FADE_FADING} fade_state_t;

endpackage

// File: rtl/led_fade.sv
// Frame-paced brightness fade: steps leds_pwm by one toward target every FADE_FRAMES frame ticks.
module led_fade
  import led_ctrl_pkg::*;
#(
  parameter int FADE_FRAMES = 4
) (
  input  logic       clk12MHz,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic [2:0] target,
  output logic [2:0] leds_pwm,
  output logic       fading
);

  localparam int               DIV_W    = (FADE_FRAMES > 1) ? $clog2(FADE_FRAMES) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FADE_FRAMES - 1);

  fade_state_t      state, state_nxt;
  logic [DIV_W-1:0] div, div_nxt;
  logic [2:0]       pwm, pwm_nxt;

  always_ff @(posedge clk12MHz or posedge reset) begin
    if (reset) begin
      state <= FADE_STEADY;
      div   <= '0;
      pwm   <= '0;
    end else begin
      state <= state_nxt;
      div   <= div_nxt;
      pwm   <= pwm_nxt;
    end
  end

  // Divider parks at 0 while steady; a mid-fade target change keeps the divider phase.
  always_comb begin
    state_nxt = state;
    div_nxt   = div;
    pwm_nxt   = pwm;
    case (state)
      FADE_STEADY: begin
        div_nxt = '0;
        if (pwm != target) state_nxt = FADE_FADING;
      end
      FADE_FADING: begin
        if (pwm == target) begin
          state_nxt = FADE_STEADY;
          div_nxt   = '0;
        end else if (frame_tick) begin
          if (div == DIV_LAST) begin
            div_nxt = '0;
            pwm_nxt = (target > pwm) ? pwm + 3'd1 : pwm - 3'd1;
          end else begin
            div_nxt = div + 1'b1;
          end
        end
      end
    endcase
  end

  assign leds_pwm = pwm;
  assign fading   = (pwm != target);

endmodule

// File: rtl/led_frame_ctrl.sv
// Bus-facing LED matrix controller: double-buffered rows committed on frame boundaries,
// frame counter, swap FSM and brightness fade.
module led_frame_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int FRAME_CYCLES = 8192,
  parameter int FADE_FRAMES  = 4
) (
  input  logic       clk12MHz,
  input  logic       reset,
  input  logic       bus_valid,
  input  logic       bus_we,
  input  logic [2:0] bus_addr,
  input  logic [7:0] bus_wdata,
  output logic       bus_ready,
  output logic       bus_rvalid,
  output logic [7:0] bus_rdata,
  output logic [7:0] leds1,
  output logic [7:0] leds2,
  output logic [7:0] leds3,
  output logic [7:0] leds4,
  output logic [2:0] leds_pwm,
  output logic       frame_tick
);

  localparam int              FC_W    = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(FRAME_CYCLES - 1);

  logic [FC_W-1:0] frame_cnt;
  swap_state_t     swap_state, swap_nxt;
  logic [7:0]      back_rows  [4];
  logic [7:0]      front_rows [4];
  logic [2:0]      target;
  logic            fading, pending, commit;
  logic            row_addr, wr_acc, rd_acc, ctrl_swap;
  logic [7:0]      rd_mux, status_word;
  logic [7:0]      rdata_p1;
  logic            vld_p1;

  assign frame_tick = (frame_cnt == FC_LAST);
  assign pending    = (swap_state == SWAP_PENDING);
  assign row_addr   = ~bus_addr[2];
  // Row writes stall while a commit is outstanding so the committed frame cannot tear.
  assign bus_ready  = ~(bus_valid & bus_we & row_addr & pending);
  assign wr_acc     = bus_valid & bus_ready & bus_we;
  assign rd_acc     = bus_valid & ~bus_we;
  assign ctrl_swap  = wr_acc & (bus_addr == ADDR_CTRL) & bus_wdata[0];

  always_ff @(posedge clk12MHz or posedge reset) begin
    if (reset) frame_cnt <= '0;
    else if (frame_tick) frame_cnt <= '0;
    else frame_cnt <= frame_cnt + 1'b1;
  end

  always_ff @(posedge clk12MHz or posedge reset) begin
    if (reset) swap_state <= SWAP_IDLE;
    else swap_state <= swap_nxt;
  end

  always_comb begin
    swap_nxt = swap_state;
    commit   = 1'b0;
    case (swap_state)
      SWAP_IDLE:    if (ctrl_swap) swap_nxt = SWAP_PENDING;
      SWAP_PENDING: if (frame_tick) begin
        swap_nxt = SWAP_IDLE;
        commit   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk12MHz or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        back_rows[i]  <= '0;
        front_rows[i] <= '0;
      end
      target <= '0;
    end else begin
      if (commit) front_rows <= back_rows;
      if (wr_acc && row_addr) back_rows[bus_addr[1:0]] <= bus_wdata;
      if (wr_acc && (bus_addr == ADDR_BRIGHT)) target <= bus_wdata[2:0];
    end
  end

  always_comb begin
    status_word = '0;
    status_word[STAT_SWAP_BIT]     = pending;
    status_word[STAT_FADE_BIT]     = fading;
    status_word[STAT_PWM_LSB +: 3] = leds_pwm;
    rd_mux = '0;
    case (bus_addr)
      ADDR_ROW0, ADDR_ROW1, ADDR_ROW2, ADDR_ROW3: rd_mux = back_rows[bus_addr[1:0]];
      ADDR_BRIGHT: rd_mux = {5'b0, target};
      ADDR_STATUS: rd_mux = status_word;
      default:     rd_mux = '0;
    endcase
  end

  // Read response stage: data is forced to zero whenever it is not qualified.
  always_ff @(posedge clk12MHz or posedge reset) begin
    if (reset) begin
      vld_p1   <= 1'b0;
      rdata_p1 <= '0;
    end else begin
      vld_p1   <= rd_acc;
      rdata_p1 <= rd_acc ? rd_mux : '0;
    end
  end

  assign bus_rvalid = vld_p1;
  assign bus_rdata  = rdata_p1;
  assign leds1 = front_rows[0];
  assign leds2 = front_rows[1];
  assign leds3 = front_rows[2];
  assign leds4 = front_rows[3];

  led_fade #(.FADE_FRAMES(FADE_FRAMES)) u_fade (
    .clk12MHz  (clk12MHz),
    .reset     (reset),
    .frame_tick(frame_tick),
    .target    (target),
    .leds_pwm  (leds_pwm),
    .fading    (fading)
  );

endmodule

// File: tb/tb_led_frame_ctrl.sv
// Directed bench for led_frame_ctrl: register-map vector table plus swap, fade and reset sequences.
module tb_led_frame_ctrl;

  localparam int FC = 16;
  localparam int FF = 4;

  logic       clk12MHz = 1'b0;
  logic       reset    = 1'b1;
  logic       bus_valid = 1'b0, bus_we = 1'b0;
  logic [2:0] bus_addr = '0;
  logic [7:0] bus_wdata = '0;
  logic       bus_ready, bus_rvalid, frame_tick;
  logic [7:0] bus_rdata, leds1, leds2, leds3, leds4;
  logic [2:0] leds_pwm;

  int n_cmp = 0;
  int n_bad = 0;

  led_frame_ctrl #(.FRAME_CYCLES(FC), .FADE_FRAMES(FF)) dut (
    .clk12MHz(clk12MHz), .reset(reset),
    .bus_valid(bus_valid), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_ready(bus_ready), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
    .leds1(leds1), .leds2(leds2), .leds3(leds3), .leds4(leds4),
    .leds_pwm(leds_pwm), .frame_tick(frame_tick)
  );

  always #5 clk12MHz = ~clk12MHz;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [7:0] d, output int stalls);
    stalls = 0;
    bus_valid = 1'b1; bus_we = 1'b1; bus_addr = a; bus_wdata = d;
    #1;
    while (!bus_ready && stalls < 4 * FC) begin
      @(posedge clk12MHz); #1;
      stalls++;
    end
    @(posedge clk12MHz); #1;
    bus_valid = 1'b0; bus_we = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic rv, output logic [7:0] d);
    bus_valid = 1'b1; bus_we = 1'b0; bus_addr = a;
    @(posedge clk12MHz); #1;
    bus_valid = 1'b0;
    rv = bus_rvalid;
    d  = bus_rdata;
  endtask

  task automatic read_check(input string name, input logic [2:0] a, input logic [7:0] exp);
    logic       rv;
    logic [7:0] d;
    bus_read(a, rv, d);
    check({name, "_rvalid"}, int'(rv), 1);
    check(name, int'(d), int'(exp));
  endtask

  // Returns inside the cycle whose closing edge is a frame tick.
  task automatic wait_tick_cycle();
    int n = 0;
    while (!frame_tick && n < 4 * FC) begin
      @(posedge clk12MHz); #1;
      n++;
    end
    if (!frame_tick) begin
      n_cmp++; n_bad++;
      $display("FAIL tick_timeout: got no frame_tick, expected one within %0d cycles", 4 * FC);
    end
  endtask

  task automatic wait_tick();
    wait_tick_cycle();
    @(posedge clk12MHz); #1;
  endtask

  typedef struct {
    logic       we;
    logic [2:0] a;
    logic [7:0] d;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[22];

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000 time units");
    $fatal(1);
  end

  initial begin
    int         st;
    logic       saw_ready;
    int         n;

    tbl[0]  = '{1'b0, 3'd0, 8'h00, 8'h00};
    tbl[1]  = '{1'b0, 3'd1, 8'h00, 8'h00};
    tbl[2]  = '{1'b0, 3'd2, 8'h00, 8'h00};
    tbl[3]  = '{1'b0, 3'd3, 8'h00, 8'h00};
    tbl[4]  = '{1'b0, 3'd4, 8'h00, 8'h00};
    tbl[5]  = '{1'b0, 3'd5, 8'h00, 8'h00};
    tbl[6]  = '{1'b0, 3'd6, 8'h00, 8'h00};
    tbl[7]  = '{1'b0, 3'd7, 8'h00, 8'h00};
    tbl[8]  = '{1'b1, 3'd0, 8'hA5, 8'h00};
    tbl[9]  = '{1'b1, 3'd1, 8'h3C, 8'h00};
    tbl[10] = '{1'b1, 3'd2, 8'hFF, 8'h00};
    tbl[11] = '{1'b1, 3'd3, 8'h01, 8'h00};
    tbl[12] = '{1'b0, 3'd0, 8'h00, 8'hA5};
    tbl[13] = '{1'b0, 3'd1, 8'h00, 8'h3C};
    tbl[14] = '{1'b0, 3'd2, 8'h00, 8'hFF};
    tbl[15] = '{1'b0, 3'd3, 8'h00, 8'h01};
    tbl[16] = '{1'b1, 3'd6, 8'hFF, 8'h00};
    tbl[17] = '{1'b0, 3'd6, 8'h00, 8'h00};
    tbl[18] = '{1'b1, 3'd7, 8'h77, 8'h00};
    tbl[19] = '{1'b0, 3'd7, 8'h00, 8'h00};
    tbl[20] = '{1'b1, 3'd4, 8'hFE, 8'h00};
    tbl[21] = '{1'b0, 3'd4, 8'h00, 8'h00};

    // Reset state while reset is held
    #1;
    check("rst_ready", int'(bus_ready), 1);
    check("rst_pwm", int'(leds_pwm), 0);
    check("rst_tick", int'(frame_tick), 0);
    check("rst_rvalid", int'(bus_rvalid), 0);
    check("rst_rdata", int'(bus_rdata), 0);
    #21 reset = 1'b0;
    @(posedge clk12MHz); #1;

    for (int i = 0; i < 22; i++) begin
      if (tbl[i].we) begin
        bus_write(tbl[i].a, tbl[i].d, st);
        check($sformatf("vec%0d_stall", i), st, 0);
      end else begin
        read_check($sformatf("vec%0d_rd", i), tbl[i].a, tbl[i].exp);
      end
    end
    @(posedge clk12MHz); #1;
    check("idle_rvalid", int'(bus_rvalid), 0);
    check("idle_rdata", int'(bus_rdata), 0);
    check("no_swap_leds", int'({leds1, leds2, leds3, leds4}), 0);

    // Swap commit with a row write stalled across the committing tick
    wait_tick();
    bus_write(3'd4, 8'h01, st);
    read_check("pend_status", 3'd6, 8'h01);
    check("pend_leds1", int'(leds1), 0);
    bus_valid = 1'b1; bus_we = 1'b1; bus_addr = 3'd0; bus_wdata = 8'h55;
    #1;
    saw_ready = 1'b0;
    n = 0;
    while (!frame_tick && n < 4 * FC) begin
      if (bus_ready) saw_ready = 1'b1;
      @(posedge clk12MHz); #1;
      n++;
    end
    check("stall_before_tick", int'(saw_ready), 0);
    check("stall_at_tick", int'(bus_ready), 0);
    check("pre_tick_leds", int'({leds1, leds2, leds3, leds4}), 0);
    @(posedge clk12MHz); #1;
    check("commit_leds", int'({leds1, leds2, leds3, leds4}), 32'hA53CFF01);
    check("ready_after_tick", int'(bus_ready), 1);
    @(posedge clk12MHz); #1;
    bus_valid = 1'b0; bus_we = 1'b0;
    check("front_kept", int'(leds1), 8'hA5);
    read_check("back_row0", 3'd0, 8'h55);
    read_check("swap_done_status", 3'd6, 8'h00);

    // Swap request landing on the tick edge commits one frame later
    wait_tick_cycle();
    bus_write(3'd4, 8'h01, st);
    check("coincide_no_copy", int'(leds1), 8'hA5);
    read_check("coincide_status", 3'd6, 8'h01);
    wait_tick();
    check("coincide_copy", int'({leds1, leds2, leds3, leds4}), 32'h553CFF01);

    // Fade up 0 -> 7, then down 7 -> 2
    wait_tick();
    bus_write(3'd5, 8'h07, st);
    for (int t = 1; t <= 28; t++) begin
      wait_tick();
      check($sformatf("fade_up_t%0d", t), int'(leds_pwm), t / 4);
    end
    read_check("fade_up_status", 3'd6, 8'h1C);
    bus_write(3'd5, 8'h02, st);
    for (int t = 1; t <= 24; t++) begin
      wait_tick();
      check($sformatf("fade_dn_t%0d", t), int'(leds_pwm), (7 - t / 4 < 2) ? 2 : 7 - t / 4);
    end
    read_check("fade_dn_status", 3'd6, 8'h08);

    // Reset mid-fade with a swap pending
    bus_write(3'd5, 8'h07, st);
    for (int t = 1; t <= 4; t++) wait_tick();
    check("mid_fade_pwm", int'(leds_pwm), 3);
    bus_write(3'd4, 8'h01, st);
    read_check("mid_status", 3'd6, 8'h0F);
    #2 reset = 1'b1;
    #1;
    check("async_pwm", int'(leds_pwm), 0);
    check("async_leds", int'({leds1, leds2, leds3, leds4}), 0);
    check("async_rvalid", int'(bus_rvalid), 0);
    check("async_tick", int'(frame_tick), 0);
    @(negedge clk12MHz);
    reset = 1'b0;
    @(posedge clk12MHz); #1;
    read_check("post_rst_status", 3'd6, 8'h00);
    read_check("post_rst_bright", 3'd5, 8'h00);
    bus_write(3'd0, 8'h99, st);
    check("post_rst_wr_stall", st, 0);
    wait_tick();
    check("no_stale_swap", int'(leds1), 0);
    check("post_rst_pwm", int'(leds_pwm), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
